bit_serial_adder: RTL and testbench

//   Multi-bit adder that pushes operands LSB-first through one instance of the team's

---
 rtl/bit_serial_adder_if.sv | 32 +++
 rtl/bit_serial_adder.sv | 143 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake bundle for bit_serial_adder.
//   master: start, a, b and cin are outputs; busy, done, sum and cout are inputs (the requester).
//   slave:  the mirror image, used by the adder itself.
//   start    request an addition (seen only while the adder is idle)
//   a, b     WIDTH-bit operands
//   cin      carry-in
//   busy     bit slices are being processed
//   done     one-cycle pulse marking a fresh result on sum/cout
//   sum      WIDTH-bit result, held until the next completion
//   cout     carry-out, held until the next completion
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one shared full adder processes the operands LSB-first,
// one bit per clock. A carry flip-flop links successive bit slices.
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   bit_serial_adder_if slave modport (start/a/b/cin in, busy/done/sum/cout out)
// The result appears on sum/cout only on the edge that enters DONE. Partial
// results stay inside the shift register and are never visible on sum.

// Single-bit full adder used as the shared bit-slice datapath.
//   a, b, cin   operand bits and carry-in
//   sum, cout   sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (state == ADD) && (cnt == CNT_LAST);
    assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

    // State register; reset aborts any operation straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so a request while
    // busy or done is simply dropped. DONE always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured on the accepting edge, so later changes
    // on a/b/cin are harmless. Each ADD edge consumes the LSBs, shifts the sum
    // bit into the top of res_sr and keeps the carry for the next slice. The
    // counter is not advanced on the final slice, so it never wraps even when
    // WIDTH is a power of two. sum/cout are only written on the final slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            res_sr <= res_next;
            carry  <= fa_cout;
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            if (!last_bit) begin
                cnt <= cnt + CNT_ONE;
            end
            if (last_bit) begin
                sum_q  <= res_next;
                cout_q <= fa_cout;
            end
        end
    end

    // Status outputs are pure decodes of the state.
    always_comb begin
        bus.busy = (state == ADD);
        bus.done = (state == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder.
// An 8-bit instance runs a table of directed vectors plus hand-written
// sequences (ignored start, mid-operation reset, continuous start). A 4-bit
// instance is swept over all 512 {a,b,cin} combinations.
module tb_bit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    bit_serial_adder_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_if #(.WIDTH(4)) bus4 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [10];

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present operands with a one-cycle start pulse; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
    endtask

    // Full operation on the 8-bit unit with latency, busy length, sum
    // stability and done pulse width checks. Returns with the unit idle.
    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        int         cyc;
        int         busy_cnt;
        int         done_cyc;
        bit         stable;
        logic [7:0] prev_sum;
        applyStimulus(a, b, cin);
        cyc      = 1;
        busy_cnt = 0;
        done_cyc = 0;
        stable   = 1'b1;
        prev_sum = bus8.sum;
        while (done_cyc == 0 && cyc <= 30) begin
            if (bus8.done) begin
                done_cyc = cyc;
            end else begin
                if (bus8.busy) busy_cnt++;
                if (bus8.sum !== prev_sum) stable = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput({name, "_done_latency"}, done_cyc, 9);
        checkOutput({name, "_busy_cycles"}, busy_cnt, 8);
        checkOutput({name, "_sum_hidden"}, {31'd0, stable}, 32'd1);
        checkOutput({name, "_sum"}, {24'd0, bus8.sum}, {24'd0, exp_sum});
        checkOutput({name, "_cout"}, {31'd0, bus8.cout}, {31'd0, exp_cout});
        @(posedge clk);
        #1;
        checkOutput({name, "_done_width"}, {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        int         done_cnt;
        int         last_done;
        bit         ok;
        logic [7:0] exp_hold;
        logic [8:0] combo;
        logic [4:0] ref4;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, bus8.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus8.done}, 32'd0);
        checkOutput("reset_sum", {24'd0, bus8.sum}, 32'd0);
        checkOutput("reset_cout", {31'd0, bus8.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout);
        end

        // start while busy is ignored; one done, original operands.
        $display("[TB] ignored start while busy");
        applyStimulus(8'h5A, 8'h3C, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b1; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus8.done) begin
                done_cnt++;
                checkOutput("ignored_start_sum", {24'd0, bus8.sum}, 32'h96);
                checkOutput("ignored_start_cout", {31'd0, bus8.cout}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("ignored_start_done_count", done_cnt, 1);

        // Reset in the 4th ADD cycle.
        $display("[TB] reset mid-operation");
        applyStimulus(8'hFF, 8'h01, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_abort_busy", {31'd0, bus8.busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, bus8.busy}, 32'd0);
        checkOutput("abort_done", {31'd0, bus8.done}, 32'd0);
        checkOutput("abort_sum", {24'd0, bus8.sum}, 32'd0);
        checkOutput("abort_cout", {31'd0, bus8.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus8.done) done_cnt++;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        runOp("after_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // start held high: one result every 10 cycles, sum stable in between.
        $display("[TB] continuous start");
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0; bus8.start = 1'b1;
        done_cnt  = 0;
        last_done = 0;
        ok        = 1'b1;
        exp_hold  = 8'h47;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus8.done) begin
                if (done_cnt > 0 && (c - last_done) != 10) ok = 1'b0;
                done_cnt++;
                last_done = c;
                exp_hold  = 8'h96;
            end
            if (bus8.sum !== exp_hold) ok = 1'b0;
        end
        bus8.start = 1'b0;
        checkOutput("continuous_done_count", done_cnt, 4);
        checkOutput("continuous_spacing_and_hold", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;

        // Exhaustive 4-bit sweep.
        $display("[TB] exhaustive 4-bit sweep");
        for (int i = 0; i < 512; i++) begin
            combo      = 9'(i);
            bus4.a     = combo[3:0];
            bus4.b     = combo[7:4];
            bus4.cin   = combo[8];
            bus4.start = 1'b1;
            ref4 = {1'b0, combo[3:0]} + {1'b0, combo[7:4]} + {4'd0, combo[8]};
            @(posedge clk);
            #1;
            bus4.start = 1'b0;
            for (int k = 0; k < 20 && !bus4.done; k++) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (!bus4.done || {bus4.cout, bus4.sum} !== ref4) begin
                errors++;
                $display("[TB] FAIL exhaustive4: Input combination %0d failed. got done=%0b {cout,sum}=0x%0h, expected 0x%0h",
                         i, bus4.done, {bus4.cout, bus4.sum}, ref4);
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
